score_bcd_counter: RTL



---
 rtl/score_bcd_if.sv | 25 ++
 rtl/score_bcd_counter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/score_bcd_if.sv
// Award handshake and score display bundle for the brick-game score counter.
// The master modport belongs to game logic; the slave modport belongs to the counter.
interface score_bcd_if #(
    parameter int DIGITS = 4
);
    logic                  add_valid;
    logic [3:0]            add_val;
    logic                  add_ready;
    logic                  clear;
    logic                  game_over;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   high_bcd;
    logic                  done;
    logic                  overflow;

    modport master (
        output add_valid, add_val, clear, game_over,
        input  add_ready, score_bcd, high_bcd, done, overflow
    );

    modport slave (
        input  add_valid, add_val, clear, game_over,
        output add_ready, score_bcd, high_bcd, done, overflow
    );
endinterface

// File: rtl/score_bcd_counter.sv
// Saturating multi-digit BCD score accumulator with high-score tracking.
// Awards ripple through one digit per clock in a working copy, so the displayed score never shows partial sums.
module score_bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    score_bcd_if.slave  bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        COMMIT
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     score_q, score_d;
    logic [W-1:0]     high_q, high_d;
    logic [W-1:0]     work_q, work_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             pending_go_q, pending_go_d;

    logic [4:0]       digit_sum;
    logic             go_now;

    always_comb begin
        // NOTE: every value driven here gets a default first so no path leaves a latch behind.
        state_d      = state_q;
        score_d      = score_q;
        high_d       = high_q;
        work_d       = work_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        overflow_d   = overflow_q;
        pending_go_d = pending_go_q;
        done_d       = 1'b0;
        digit_sum    = {1'b0, work_q[4*idx_q +: 4]} + {1'b0, carry_q};
        go_now       = bus.game_over || pending_go_q;

        if (bus.clear) begin
            // A game-over racing the clear still sees the pre-clear score.
            if (go_now && (score_q > high_q)) high_d = score_q;
            score_d      = '0;
            overflow_d   = 1'b0;
            pending_go_d = 1'b0;
            state_d      = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_now) begin
                        if (score_q > high_q) high_d = score_q;
                        pending_go_d = 1'b0;
                    end
                    if (bus.add_valid) begin
                        carry_d = (bus.add_val > 4'd9) ? 4'd9 : bus.add_val;
                        work_d  = score_q;
                        idx_d   = '0;
                        state_d = ADD;
                    end
                end
                ADD: begin
                    if (bus.game_over) pending_go_d = 1'b1;
                    if (digit_sum > 5'd9) begin
                        work_d[4*idx_q +: 4] = 4'(digit_sum - 5'd10);
                        carry_d              = 4'd1;
                    end else begin
                        work_d[4*idx_q +: 4] = digit_sum[3:0];
                        carry_d              = 4'd0;
                    end
                    idx_d = idx_q + 1'b1;
                    // Fixed DIGITS-cycle walk with no early exit keeps latency constant.
                    if (idx_q == IDX_W'(DIGITS - 1)) state_d = COMMIT;
                end
                COMMIT: begin
                    if (bus.game_over) pending_go_d = 1'b1;
                    if (carry_q != 4'd0) begin
                        score_d    = ALL_NINES;
                        overflow_d = 1'b1;
                    end else begin
                        score_d = work_q;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= '0;
            high_q       <= '0;
            work_q       <= '0;
            idx_q        <= '0;
            carry_q      <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            pending_go_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            high_q       <= high_d;
            work_q       <= work_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            pending_go_q <= pending_go_d;
        end
    end

    assign bus.add_ready = (state_q == IDLE);
    assign bus.score_bcd = score_q;
    assign bus.high_bcd  = high_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
endmodule
